// File: rtl/arith_pkg.sv
// arith_pkg -- shared arithmetic-unit definitions.
//   state_t         : sequencer states (IDLE, INIT, ITER, FIX, DONE) used by
//                     the sequential divider.
//   twos_complement : modulo-2^ARITH_MAX_W negation, also used by the
//                     sequential Booth multiplier. Callers cast the result
//                     back down to their own width.
//   cnt_width       : width of an iteration counter that must hold n.
//   CNT_W           : counter width for the default 8-bit datapath.
package arith_pkg;

  localparam int ARITH_MAX_W   = 64;
  localparam int ARITH_N_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic [ARITH_MAX_W-1:0] twos_complement(
    input logic [ARITH_MAX_W-1:0] v
  );
    return ~v + ARITH_MAX_W'(1);
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = $clog2(ARITH_N_DEFAULT + 1);

endpackage

// File: rtl/nr_div_step.sv
// nr_div_step -- one combinational non-restoring division iteration.
// Ports:
//   a      [N:0]   partial remainder (two's complement, N+1 bits)
//   q      [N-1:0] partial quotient / remaining dividend bits
//   m      [N-1:0] divisor magnitude (unsigned)
//   a_next [N:0]   partial remainder after shift and add/subtract
//   q_next [N-1:0] quotient shifted left with the new quotient bit in bit 0
module nr_div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] q,
  input  logic [N-1:0] m,
  output logic [N:0]   a_next,
  output logic [N-1:0] q_next
);

  logic [N:0] a_shift;

  // {A,Q} shifted left: the top bit of Q moves into A.
  assign a_shift = {a[N-1:0], q[N-1]};

  // Sign of the old A picks subtract (A >= 0) or add-back (A < 0).
  assign a_next = a[N] ? (a_shift + {1'b0, m}) : (a_shift - {1'b0, m});

  // New quotient bit is 1 when the partial remainder stayed non-negative.
  assign q_next = {q[N-2:0], ~a_next[N]};

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// seq_nonrestoring_divider -- multi-cycle non-restoring integer divider,
// one quotient bit per clock.
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request pulse, sampled only in IDLE
//   dividend     N-bit dividend, captured when start is accepted
//   divisor      N-bit divisor, captured when start is accepted
//   quotient     N-bit quotient, truncated toward zero
//   remainder    N-bit remainder, sign follows the dividend
//   busy         high from the cycle after acceptance until DONE completes
//   done         one-cycle pulse; results valid from this cycle onward
//   div_by_zero  last operation had a zero divisor
//   overflow     last operation was most-negative / -1 (signed build only)
// Configuration:
//   SEQ_DIV_SIGNED_EN defined   -> two's-complement operands
//   SEQ_DIV_SIGNED_EN undefined -> unsigned operands, overflow is always 0
module seq_nonrestoring_divider
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = cnt_width(N);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  state_t        state_reg;
  logic [N:0]    a_reg;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  m_reg;
  logic [CW-1:0] count_reg;
  logic          sd_reg;
  logic          sv_reg;
  logic          dz_reg;
  logic          ov_reg;

  logic          sd_in;
  logic          sv_in;
  logic          ov_in;
  logic          dz_in;

`ifdef SEQ_DIV_SIGNED_EN
  assign sd_in = dividend[N-1];
  assign sv_in = divisor[N-1];
  assign ov_in = (dividend == MOST_NEG) && (&divisor);
`else
  assign sd_in = 1'b0;
  assign sv_in = 1'b0;
  assign ov_in = 1'b0;
`endif
  assign dz_in = (divisor == '0);

  // Negations used for magnitudes in INIT and sign fix-up in FIX. Q holds the
  // raw dividend in INIT and the unsigned quotient in FIX, so one negator
  // serves both.
  logic [N-1:0] q_neg;
  logic [N-1:0] m_neg;
  logic [N:0]   a_fix;
  logic [N-1:0] r_neg;

  assign q_neg = N'(twos_complement(ARITH_MAX_W'(q_reg)));
  assign m_neg = N'(twos_complement(ARITH_MAX_W'(m_reg)));
  // Final add-back when the last iteration left a negative partial remainder.
  assign a_fix = a_reg[N] ? (a_reg + {1'b0, m_reg}) : a_reg;
  assign r_neg = N'(twos_complement(ARITH_MAX_W'(a_fix[N-1:0])));

  logic [N:0]   a_step;
  logic [N-1:0] q_step;

  nr_div_step #(.N(N)) u_step (
    .a      (a_reg),
    .q      (q_reg),
    .m      (m_reg),
    .a_next (a_step),
    .q_next (q_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      count_reg   <= '0;
      sd_reg      <= 1'b0;
      sv_reg      <= 1'b0;
      dz_reg      <= 1'b0;
      ov_reg      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // Raw operands parked in Q/M; INIT turns them into magnitudes,
            // special cases use the raw dividend directly.
            q_reg       <= dividend;
            m_reg       <= divisor;
            a_reg       <= '0;
            sd_reg      <= sd_in;
            sv_reg      <= sv_in;
            dz_reg      <= dz_in;
            ov_reg      <= ov_in;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b1;
            state_reg   <= (dz_in || ov_in) ? DONE : INIT;
          end
        end
        INIT: begin
          a_reg     <= '0;
          q_reg     <= sd_reg ? q_neg : q_reg;
          m_reg     <= sv_reg ? m_neg : m_reg;
          count_reg <= CW'(N);
          state_reg <= ITER;
        end
        ITER: begin
          a_reg     <= a_step;
          q_reg     <= q_step;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          a_reg     <= a_fix;
          quotient  <= (sd_reg ^ sv_reg) ? q_neg : q_reg;
          remainder <= sd_reg ? r_neg : a_fix[N-1:0];
          state_reg <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (dz_reg) begin
            quotient    <= '1;
            remainder   <= q_reg;
            div_by_zero <= 1'b1;
          end
          if (ov_reg) begin
            quotient  <= MOST_NEG;
            remainder <= '0;
            overflow  <= 1'b1;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
